crono_ctrl: RTL and testbench

- Command controller for the stopwatch counter chain; replaces the single-button run toggle.
- Synchronizes and debounces two active-high buttons, `start` and `lap`, and classifies `start` presses as short or long.
- Runs a 4-state FSM that drives the chain's count enable, a synchronous clear pulse, and a display-freeze (lap) level.
- Sits between the board buttons and the decade counters / display controller.

---
 rtl/crono_ctrl.sv | 136 +++++++++++++
 tb/tb_crono_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/crono_ctrl.sv
// Stopwatch command controller: debounces the start/lap buttons, tells short
// start presses from long ones, and sequences run / lap-freeze / clear.
module crono_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter int CNT_W             = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       run_en,
    output logic       clear,
    output logic       freeze,
    output logic [1:0] state,
    output logic       ready
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_STOPPED = 2'd2;
    localparam logic [1:0] S_LAP     = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_PRESS_CYCLES);

    // Bit 0 carries the start button, bit 1 the lap button.
    logic [1:0] raw;
    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] deb;
    logic [1:0] deb_q;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [CNT_W-1:0] hold_cnt;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       clear_q;
    logic       clear_d;
    logic       ready_q;

    logic start_fall;
    logic lap_rise;
    logic short_evt;
    logic long_evt;

    assign raw = {btn_lap, btn_start};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            deb_q  <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Saturating at LONG_MAX doubles as the "long press already fired" flag.
    always_ff @(posedge clk) begin
        if (rst || !deb[0]) begin
            hold_cnt <= '0;
        end else if (hold_cnt != LONG_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign start_fall = ~deb[0] & deb_q[0];
    assign lap_rise   = deb[1] & ~deb_q[1];
    assign long_evt   = deb[0] && (hold_cnt == LONG_LAST);
    assign short_evt  = start_fall && (hold_cnt != LONG_MAX);

    // A start event in the same cycle as a lap rise takes priority.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (short_evt) state_d = S_RUNNING;
            end
            S_RUNNING: begin
                if (short_evt)                  state_d = S_STOPPED;
                else if (!long_evt && lap_rise) state_d = S_LAP;
            end
            S_LAP: begin
                if (short_evt)                  state_d = S_STOPPED;
                else if (!long_evt && lap_rise) state_d = S_RUNNING;
            end
            S_STOPPED: begin
                if (short_evt) begin
                    state_d = S_RUNNING;
                end else if (long_evt) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            clear_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
            ready_q <= 1'b1;
        end
    end

    assign state  = state_q;
    assign clear  = clear_q;
    assign ready  = ready_q;
    assign run_en = (state_q == S_RUNNING) || (state_q == S_LAP);
    assign freeze = (state_q == S_LAP);

endmodule

// File: tb/tb_crono_ctrl.sv
// Directed bench for crono_ctrl with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20;
// expected cycle positions are hand-derived from the sync + debounce latency.
module tb_crono_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_lap;
    logic       run_en;
    logic       clear;
    logic       freeze;
    logic [1:0] state;
    logic       ready;

    int checks = 0;
    int errors = 0;

    crono_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .CNT_W            (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_lap  (btn_lap),
        .run_en   (run_en),
        .clear    (clear),
        .freeze   (freeze),
        .state    (state),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Lap press of 6 cycles, then enough idle time for the debounced release.
    task automatic lap_press();
        btn_lap = 1'b1;
        tick(6);
        btn_lap = 1'b0;
        tick(12);
    endtask

    // Short start press: the state moves exactly 7 cycles after the raw release
    // (2 sync + 4 debounce + 1 FSM register).
    task automatic short_start(input string tag, input int from_st, input int to_st);
        btn_start = 1'b1;
        tick(8);
        btn_start = 1'b0;
        tick(6);
        check({tag, "_pre"}, int'(state), from_st);
        tick(1);
        check({tag, "_post"}, int'(state), to_st);
        tick(6);
    endtask

    // 30-cycle start hold. The debounced rise lands 6 cycles in, long_evt at
    // cycle 25, so a STOPPED->IDLE transition becomes visible at cycle 26.
    task automatic long_start(input string tag, input int from_st, input int to_st);
        btn_start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (i == 25) begin
                check({tag, "_st25"}, int'(state), from_st);
                check({tag, "_clr25"}, int'(clear), 0);
            end
            if (i == 26) begin
                check({tag, "_st26"}, int'(state), to_st);
                check({tag, "_clr26"}, int'(clear), (to_st != from_st) ? 1 : 0);
            end
            if (i == 27) check({tag, "_clr27"}, int'(clear), 0);
        end
        btn_start = 1'b0;
        tick(12);
        check({tag, "_release"}, int'(state), to_st);
        check({tag, "_clr_rel"}, int'(clear), 0);
    endtask

    initial begin
        rst       = 1'b1;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        tick(3);
        check("rst_ready", int'(ready), 0);
        check("rst_state", int'(state), 0);
        rst = 1'b0;
        tick(1);
        check("ready_first", int'(ready), 1);
        tick(10);
        check("idle_state", int'(state), 0);
        check("idle_run", int'(run_en), 0);
        check("idle_freeze", int'(freeze), 0);
        check("idle_clear", int'(clear), 0);

        lap_press();
        check("lap_in_idle", int'(state), 0);

        short_start("start1", 0, 1);
        check("run_en_running", int'(run_en), 1);

        lap_press();
        check("lap1_state", int'(state), 3);
        check("lap1_freeze", int'(freeze), 1);
        check("lap1_run", int'(run_en), 1);
        lap_press();
        check("lap2_state", int'(state), 1);
        check("lap2_freeze", int'(freeze), 0);

        long_start("long_run", 1, 1);

        short_start("start2", 1, 2);
        check("run_en_stopped", int'(run_en), 0);

        lap_press();
        check("lap_in_stopped", int'(state), 2);

        long_start("long_stop", 2, 0);
        check("run_en_after_clr", int'(run_en), 0);

        for (int i = 0; i < 10; i++) begin
            btn_start = 1'b1;
            tick(2);
            btn_start = 1'b0;
            tick(2);
        end
        tick(8);
        check("glitch_state", int'(state), 0);

        short_start("start3", 0, 1);

        // Start release and lap press together: both debounced edges land in
        // the same cycle and the start event must win.
        btn_start = 1'b1;
        tick(8);
        btn_start = 1'b0;
        btn_lap   = 1'b1;
        tick(6);
        btn_lap = 1'b0;
        tick(12);
        check("simul_state", int'(state), 2);
        check("simul_freeze", int'(freeze), 0);

        short_start("start4", 2, 1);
        lap_press();
        check("pre_rst_lap", int'(state), 3);

        btn_start = 1'b1;
        tick(3);
        rst       = 1'b1;
        btn_start = 1'b0;
        tick(1);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_freeze", int'(freeze), 0);
        check("mid_rst_run", int'(run_en), 0);
        check("mid_rst_ready", int'(ready), 0);
        rst = 1'b0;
        tick(20);
        check("post_rst_state", int'(state), 0);
        check("post_rst_ready", int'(ready), 1);

        // Button held through reset: still detected as a press afterwards.
        rst       = 1'b1;
        btn_start = 1'b1;
        tick(3);
        check("held_rst_state", int'(state), 0);
        rst = 1'b0;
        tick(10);
        check("held_no_evt", int'(state), 0);
        btn_start = 1'b0;
        tick(12);
        check("held_rst_press", int'(state), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
